// File: rtl/ifu_pc_fetch_pkg.sv
// Shared encodings for the instruction fetch unit: PC source selects,
// FSM states, fault causes and the reset instruction word.
package ifu_pc_fetch_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;

    // PC source selects driven by the branch condition unit
    localparam logic PC_SRC1_PC   = 1'b0;
    localparam logic PC_SRC1_XRS1 = 1'b1;
    localparam logic PC_SRC2_4    = 1'b0;
    localparam logic PC_SRC2_IMM  = 1'b1;

    // fault_cause encodings
    localparam logic FAULT_MISALIGN = 1'b0;
    localparam logic FAULT_ACCESS   = 1'b1;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_FAULT = 3'd5
    } ifu_state_e;

endpackage

// File: rtl/ifu_pc_fetch_if.sv
// Instruction-memory request/response and decode-side handshake bundle.
// master = fetch unit, slave = memory/decode side.
interface ifu_pc_fetch_if #(
    parameter int unsigned XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            imem_rsp_err;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            fetch_fault;
    logic            fault_cause;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, inst_pc, fetch_fault, fault_cause,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, inst_pc, fetch_fault, fault_cause,
        output inst_ready
    );
endinterface

// File: rtl/ifu_pc_fetch_pc_next_gen.sv
// Next-PC generator: base/offset mux, adder, bit0 clear for register-relative
// targets, and a flag for targets that are not 4-byte aligned.
module ifu_pc_fetch_pc_next_gen
    import ifu_pc_fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] x_rs1,
    input  logic [XLEN-1:0] imm,
    input  logic            pc_src1,
    input  logic            pc_src2,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offset;
    logic [XLEN-1:0] sum;

    // Form the target and flag misalignment of the final (bit0-cleared) value
    always_comb begin
        base       = (pc_src1 == PC_SRC1_XRS1) ? x_rs1 : pc;
        offset     = (pc_src2 == PC_SRC2_IMM) ? imm : XLEN'(4);
        sum        = base + offset;
        next_pc    = {sum[XLEN-1:1], sum[0] & (pc_src1 != PC_SRC1_XRS1)};
        misaligned = (next_pc[1:0] != 2'b00);
    end
endmodule

// File: rtl/ifu_pc_fetch.sv
// Fetch unit for a multi-cycle core: owns the architectural PC, fetches one
// instruction at a time, hands it to decode and applies the next PC at commit.
// Trap redirects override every other PC source.
module ifu_pc_fetch
    import ifu_pc_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_src1,
    input  logic              pc_src2,
    input  logic [XLEN-1:0]   x_rs1,
    input  logic [XLEN-1:0]   imm,
    input  logic              commit,
    input  logic              trap_valid,
    input  logic [XLEN-1:0]   trap_pc,
    ifu_pc_fetch_if.master    bus
);
    ifu_state_e      state;
    ifu_state_e      state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;
    logic            req_valid;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            fetch_fault;
    logic            fault_cause;
    logic            req_hs;
    logic            inst_hs;
    logic            commit_exec;

    ifu_pc_fetch_pc_next_gen #(
        .XLEN (XLEN)
    ) u_pc_next_gen (
        .pc         (pc),
        .x_rs1      (x_rs1),
        .imm        (imm),
        .pc_src1    (pc_src1),
        .pc_src2    (pc_src2),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    assign req_hs      = req_valid && bus.imem_req_ready;
    assign inst_hs     = inst_valid && bus.inst_ready;
    assign commit_exec = (state == ST_EXEC) && commit;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc;
    assign bus.inst_valid     = inst_valid;
    assign bus.inst           = inst;
    assign bus.inst_pc        = inst_pc;
    assign bus.fetch_fault    = fetch_fault;
    assign bus.fault_cause    = fault_cause;

    // Next-state logic; a trap overrides the normal transition
    always_comb begin
        state_next = state;
        unique case (state)
            ST_FETCH: if (req_hs) state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_next = bus.imem_rsp_err ? ST_FAULT : ST_ISSUE;
                end
            end
            ST_ISSUE: if (inst_hs) state_next = ST_EXEC;
            ST_EXEC: begin
                if (commit) begin
                    state_next = misaligned ? ST_FAULT : ST_FETCH;
                end
            end
            ST_DRAIN: if (bus.imem_rsp_valid) state_next = ST_FETCH;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FETCH;
        endcase
        if (trap_valid) begin
            // Drain only while a response is still owed; a response landing
            // in the trap cycle itself settles the outstanding request.
            if ((state == ST_FETCH && req_hs) ||
                ((state == ST_WAIT || state == ST_DRAIN) && !bus.imem_rsp_valid)) begin
                state_next = ST_DRAIN;
            end else begin
                state_next = ST_FETCH;
            end
        end
    end

    // State register plus handshake/fault flags derived from the next state;
    // registering req_valid keeps it low while reset is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            req_valid   <= 1'b0;
            inst_valid  <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_next;
            req_valid   <= (state_next == ST_FETCH);
            inst_valid  <= (state_next == ST_ISSUE);
            fetch_fault <= (state_next == ST_FAULT);
        end
    end

    // Architectural PC: trap target first, then the committed next PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (trap_valid) begin
            pc <= trap_pc;
        end else if (commit_exec && !misaligned) begin
            pc <= next_pc;
        end
    end

    // Instruction word, its PC and the fault cause presented to decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst        <= NOP;
            inst_pc     <= RESET_PC;
            fault_cause <= FAULT_MISALIGN;
        end else if (!trap_valid) begin
            if (state == ST_WAIT && bus.imem_rsp_valid) begin
                inst_pc <= pc;
                if (bus.imem_rsp_err) begin
                    fault_cause <= FAULT_ACCESS;
                end else begin
                    inst <= bus.imem_rsp_data;
                end
            end
            if (commit_exec && misaligned) begin
                inst_pc     <= pc;
                fault_cause <= FAULT_MISALIGN;
            end
        end
    end
endmodule

// File: tb/tb_ifu_pc_fetch.sv
// Directed bench for ifu_pc_fetch: sequential fetch, JALR, misaligned branch,
// access fault, trap recovery, trap during WAIT and trap-vs-commit priority.
module tb_ifu_pc_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_src1;
    logic        pc_src2;
    logic [63:0] x_rs1;
    logic [63:0] imm;
    logic        commit;
    logic        trap_valid;
    logic [63:0] trap_pc;
    int          checks = 0;
    int          errors = 0;

    ifu_pc_fetch_if #(.XLEN(64)) bus ();

    ifu_pc_fetch #(
        .XLEN     (64),
        .RESET_PC (64'h8000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_src1    (pc_src1),
        .pc_src2    (pc_src2),
        .x_rs1      (x_rs1),
        .imm        (imm),
        .commit     (commit),
        .trap_valid (trap_valid),
        .trap_pc    (trap_pc),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a fetch request and check its address
    task automatic wait_req(input string tag, input logic [63:0] addr);
        int n = 0;
        while (!bus.imem_req_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_seen"}, 64'(bus.imem_req_valid), 64'd1);
        chk({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    // Full fetch: request handshake, good response, issue with one stall cycle
    task automatic do_fetch(input string tag, input logic [63:0] addr, input logic [31:0] word);
        wait_req(tag, addr);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        chk({tag, "_req_drop"}, 64'(bus.imem_req_valid), 64'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = word;
        bus.imem_rsp_err   = 1'b0;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        chk({tag, "_inst_valid"}, 64'(bus.inst_valid), 64'd1);
        chk({tag, "_inst"}, 64'(bus.inst), 64'(word));
        chk({tag, "_inst_pc"}, bus.inst_pc, addr);
        @(negedge clk);
        chk({tag, "_inst_hold"}, 64'(bus.inst_valid), 64'd1);
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        chk({tag, "_inst_done"}, 64'(bus.inst_valid), 64'd0);
    endtask

    task automatic do_commit(input logic s1, input logic s2, input logic [63:0] rs1v, input logic [63:0] immv);
        pc_src1 = s1;
        pc_src2 = s2;
        x_rs1   = rs1v;
        imm     = immv;
        commit  = 1'b1;
        @(negedge clk);
        commit  = 1'b0;
    endtask

    task automatic do_trap(input logic [63:0] target);
        trap_pc    = target;
        trap_valid = 1'b1;
        @(negedge clk);
        trap_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        pc_src1            = 1'b0;
        pc_src2            = 1'b0;
        x_rs1              = '0;
        imm                = '0;
        commit             = 1'b0;
        trap_valid         = 1'b0;
        trap_pc            = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        bus.inst_ready     = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        chk("rst_inst", 64'(bus.inst), 64'h13);
        chk("rst_inst_pc", bus.inst_pc, 64'h8000_0000);
        chk("rst_addr", bus.imem_addr, 64'h8000_0000);
        chk("rst_fault", 64'(bus.fetch_fault), 64'd0);
        chk("rst_cause", 64'(bus.fault_cause), 64'd0);

        // Release reset with a late response pulse; nothing is outstanding
        rst_n              = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAAD_F00D;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        chk("late_rsp_ignored", 64'(bus.inst_valid), 64'd0);

        do_fetch("f0", 64'h8000_0000, 32'h0050_0093);
        do_commit(1'b0, 1'b0, 64'h0, 64'h0);
        do_fetch("f1", 64'h8000_0004, 32'h0000_8067);

        // JALR: x_rs1 + 4 with bit0 cleared
        do_commit(1'b1, 1'b1, 64'h8000_1001, 64'd4);
        do_fetch("jalr", 64'h8000_1004, 32'hFE00_0EE3);

        // Branch to pc + imm = 0x80000002 -> misaligned fault
        do_commit(1'b0, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_EFFE);
        chk("mis_fault", 64'(bus.fetch_fault), 64'd1);
        chk("mis_cause", 64'(bus.fault_cause), 64'd0);
        chk("mis_inst_pc", bus.inst_pc, 64'h8000_1004);
        chk("mis_pc_kept", bus.imem_addr, 64'h8000_1004);
        chk("mis_no_req", 64'(bus.imem_req_valid), 64'd0);
        // A commit in FAULT must be ignored
        do_commit(1'b0, 1'b0, 64'h0, 64'h0);
        @(negedge clk);
        chk("mis_commit_ign_fault", 64'(bus.fetch_fault), 64'd1);
        chk("mis_commit_ign_req", 64'(bus.imem_req_valid), 64'd0);
        chk("mis_commit_ign_pc", bus.imem_addr, 64'h8000_1004);

        // Trap out of FAULT, then an access fault at the trap target
        do_trap(64'h8000_0010);
        chk("trap1_fault_clr", 64'(bus.fetch_fault), 64'd0);
        wait_req("acc", 64'h8000_0010);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_err   = 1'b1;
        bus.imem_rsp_data  = 32'h1111_1111;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        chk("acc_fault", 64'(bus.fetch_fault), 64'd1);
        chk("acc_cause", 64'(bus.fault_cause), 64'd1);
        chk("acc_inst_pc", bus.inst_pc, 64'h8000_0010);
        chk("acc_inst_valid", 64'(bus.inst_valid), 64'd0);
        chk("acc_no_req", 64'(bus.imem_req_valid), 64'd0);

        do_trap(64'h8000_0100);
        chk("trap2_fault_clr", 64'(bus.fetch_fault), 64'd0);
        do_fetch("trap2", 64'h8000_0100, 32'h0010_0113);

        // Trap while WAIT: the stale response is dropped
        do_commit(1'b0, 1'b0, 64'h0, 64'h0);
        wait_req("drain", 64'h8000_0104);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        do_trap(64'h8000_0200);
        chk("drain_no_req", 64'(bus.imem_req_valid), 64'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        chk("drain_no_inst", 64'(bus.inst_valid), 64'd0);
        do_fetch("post_drain", 64'h8000_0200, 32'h0020_0193);

        // Trap and commit together: trap target wins
        pc_src1    = 1'b0;
        pc_src2    = 1'b0;
        commit     = 1'b1;
        do_trap(64'h8000_0300);
        commit     = 1'b0;
        do_fetch("trap_vs_commit", 64'h8000_0300, 32'h0030_0213);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
